regfile_sb: RTL

//   Parametrised multi-port register file with a per-register busy scoreboard and write-to-read bypass.

---
 rtl/regfile_sb.sv | 134 +++++++++++++
 1 files changed

// File: rtl/regfile_sb.sv
// regfile_sb: multi-port register file with a per-register busy scoreboard.
// r0 is hard-wired to zero and never busy. W1 (load/mem) has priority over
// W0 (ALU) when both write the same register. Reads are combinational and,
// when BYPASS=1, see same-cycle writeback data before it reaches the array.
module regfile_sb #(
   parameter int WIDTH   = 32,
   parameter int REGBITS = 3,
   parameter int NRD     = 2,
   parameter int BYPASS  = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NRD*REGBITS-1:0]   ra_i,
   output logic [NRD*WIDTH-1:0]     rd_o,
   output logic [NRD-1:0]           rbusy_o,
   input  logic                     we0_i,
   input  logic [REGBITS-1:0]       wa0_i,
   input  logic [WIDTH-1:0]         wd0_i,
   input  logic                     we1_i,
   input  logic [REGBITS-1:0]       wa1_i,
   input  logic [WIDTH-1:0]         wd1_i,
   input  logic                     iss_i,
   input  logic [REGBITS-1:0]       iss_wa_i,
   output logic [(1<<REGBITS)-1:0]  busy_o,
   output logic                     wcoll_o
);

   localparam int NREG = 1 << REGBITS;

   logic [WIDTH-1:0]   regs_q [NREG];
   logic [WIDTH-1:0]   regs_d [NREG];
   logic [NREG-1:0]    busy_q;
   logic [NREG-1:0]    busy_d;
   logic               wcoll_q;
   logic               wcoll_d;

   // Writes that actually land in the array (r0 writes are dropped).
   logic               w0_live;
   logic               w1_live;

   // Per-read-port decode.
   logic [REGBITS-1:0] rd_addr [NRD];
   logic [NRD-1:0]     rd_hit0;
   logic [NRD-1:0]     rd_hit1;

   assign w0_live = we0_i && (wa0_i != '0);
   assign w1_live = we1_i && (wa1_i != '0);

   // Next array contents: W0 first, W1 afterwards so W1 wins an address tie.
   always_comb begin
      for (int r = 0; r < NREG; r++) begin
         regs_d[r] = regs_q[r];
      end
      if (w0_live) begin
         regs_d[wa0_i] = wd0_i;
      end
      if (w1_live) begin
         regs_d[wa1_i] = wd1_i;
      end
      regs_d[0] = '0;
   end

   // Scoreboard next state: a new reservation beats a completing write.
   always_comb begin
      busy_d = busy_q;
      for (int r = 1; r < NREG; r++) begin
         if (iss_i && (iss_wa_i == REGBITS'(r))) begin
            busy_d[r] = 1'b1;
         end else if ((w0_live && (wa0_i == REGBITS'(r))) ||
                      (w1_live && (wa1_i == REGBITS'(r)))) begin
            busy_d[r] = 1'b0;
         end
      end
      busy_d[0] = 1'b0;
   end

   // Collision flag: both writeback ports targeting the same nonzero register.
   always_comb begin
      wcoll_d = w0_live && w1_live && (wa0_i == wa1_i);
   end

   // State registers; reset clears data, scoreboard and flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < NREG; r++) begin
            regs_q[r] <= '0;
         end
         busy_q  <= '0;
         wcoll_q <= 1'b0;
      end else begin
         for (int r = 0; r < NREG; r++) begin
            regs_q[r] <= regs_d[r];
         end
         busy_q  <= busy_d;
         wcoll_q <= wcoll_d;
      end
   end

   // Read ports: address decode and match against live writes.
   always_comb begin
      rd_hit0 = '0;
      rd_hit1 = '0;
      for (int k = 0; k < NRD; k++) begin
         rd_addr[k] = ra_i[k*REGBITS +: REGBITS];
         rd_hit0[k] = w0_live && (wa0_i == rd_addr[k]);
         rd_hit1[k] = w1_live && (wa1_i == rd_addr[k]);
      end
   end

   // Read data and per-port stall; a forwarded write satisfies a pending source.
   always_comb begin
      rd_o    = '0;
      rbusy_o = '0;
      for (int k = 0; k < NRD; k++) begin
         if (rd_addr[k] == '0) begin
            rd_o[k*WIDTH +: WIDTH] = '0;
            rbusy_o[k]             = 1'b0;
         end else if ((BYPASS != 0) && rd_hit1[k]) begin
            rd_o[k*WIDTH +: WIDTH] = wd1_i;
            rbusy_o[k]             = 1'b0;
         end else if ((BYPASS != 0) && rd_hit0[k]) begin
            rd_o[k*WIDTH +: WIDTH] = wd0_i;
            rbusy_o[k]             = 1'b0;
         end else begin
            rd_o[k*WIDTH +: WIDTH] = regs_q[rd_addr[k]];
            rbusy_o[k]             = busy_q[rd_addr[k]];
         end
      end
   end

   assign busy_o  = busy_q;
   assign wcoll_o = wcoll_q;

endmodule
